// File: rtl/booth_dot_product_accum.sv
// Dot-product accumulator: sums a programmed number of signed Booth products into a wider signed accumulator.
// Optional build macro BOOTH_ACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module booth_dot_product_accum #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              busy,
    output logic [ACC_W-1:0]  acc_out,
    output logic              done,
    output logic              overflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]       state;
    logic [LEN_W-1:0] count;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_next;
    logic             add_ovf;

    assign prod_ext = ACC_W'($signed(prod));
    assign sum      = acc_out + prod_ext;

    // Signed overflow: operands agree in sign but the result does not.
    assign add_ovf  = (acc_out[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_out[ACC_W-1]);

`ifdef BOOTH_ACC_SATURATE_EN
    assign acc_next = add_ovf ? (acc_out[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    assign acc_next = sum;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            acc_out  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_out  <= '0;
                        overflow <= 1'b0;
                        count    <= len;
                        state    <= (len != '0) ? ACCUM : DONE;
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc_out <= acc_next;
                        count   <= count - 1'b1;
                        if (add_ovf)
                            overflow <= 1'b1;
                        if (count == LEN_W'(1))
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_dot_product_accum.sv
// Scoreboard bench: a 24-bit and a 16-bit accumulator share one stimulus stream; a monitor checks each done pulse.
module tb_booth_dot_product_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  len;
    logic        prod_valid;
    logic [15:0] prod;

    logic        busy24, done24, ovf24;
    logic [23:0] acc24;
    logic        busy16, done16, ovf16;
    logic [15:0] acc16;

    typedef struct {
        int acc;
        bit ovf;
    } exp_t;

    exp_t q24[$];
    exp_t q16[$];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    booth_dot_product_accum #(.PROD_W(16), .ACC_W(24), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .prod_valid(prod_valid), .prod(prod),
        .busy(busy24), .acc_out(acc24), .done(done24), .overflow(ovf24)
    );

    booth_dot_product_accum #(.PROD_W(16), .ACC_W(16), .LEN_W(4)) dut16 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .prod_valid(prod_valid), .prod(prod),
        .busy(busy16), .acc_out(acc16), .done(done16), .overflow(ovf16)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Holds one set of inputs across a rising edge, returning 1ns after it.
    task automatic applyStimulus(input bit s, input int l, input bit v, input int p);
        start      = s;
        len        = 4'(l);
        prod_valid = v;
        prod       = 16'(p);
        @(posedge clk);
        #1;
    endtask

    task automatic expectBoth(input int a24, input bit o24, input int a16, input bit o16);
        exp_t e;
        e.acc = a24; e.ovf = o24; q24.push_back(e);
        e.acc = a16; e.ovf = o16; q16.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (done24) begin
                if (q24.size() == 0) begin
                    checkOutput("unexpected_done24", 1, 0);
                end else begin
                    exp_t e;
                    e = q24.pop_front();
                    checkOutput("acc24", $signed(acc24), e.acc);
                    checkOutput("ovf24", int'(ovf24), int'(e.ovf));
                end
            end
            if (done16) begin
                if (q16.size() == 0) begin
                    checkOutput("unexpected_done16", 1, 0);
                end else begin
                    exp_t e;
                    e = q16.pop_front();
                    checkOutput("acc16", $signed(acc16), e.acc);
                    checkOutput("ovf16", int'(ovf16), int'(e.ovf));
                end
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0;
        @(posedge clk); #1;
        checkOutput("reset_acc", $signed(acc24), 0);
        checkOutput("reset_busy", int'(busy24), 0);
        checkOutput("reset_done", int'(done24), 0);
        checkOutput("reset_ovf", int'(ovf24), 0);
        rst = 1'b0;
        idle(2);

        $display("[TB] basic run");
        expectBoth(-78, 0, -78, 0);
        applyStimulus(1, 4, 0, 0);
        checkOutput("basic_busy_after_start", int'(busy24), 1);
        applyStimulus(0, 0, 1, -90);
        applyStimulus(0, 0, 1, 21);
        applyStimulus(0, 0, 1, -30);
        checkOutput("basic_no_early_done", int'(done24), 0);
        applyStimulus(0, 0, 1, 21);
        checkOutput("basic_done", int'(done24), 1);
        checkOutput("basic_busy_in_done", int'(busy24), 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("basic_busy_idle", int'(busy24), 0);
        checkOutput("basic_done_drop", int'(done24), 0);
        idle(1);

        $display("[TB] stalls");
        expectBoth(57, 0, 57, 0);
        applyStimulus(1, 3, 1, 999);
        applyStimulus(0, 0, 1, 100);
        idle(2);
        applyStimulus(0, 0, 1, -50);
        idle(2);
        checkOutput("stall_no_done", int'(done24), 0);
        applyStimulus(0, 0, 1, 7);
        checkOutput("stall_done", int'(done24), 1);
        idle(2);

        $display("[TB] zero length");
        expectBoth(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("zero_len_done", int'(done24), 1);
        idle(2);

        $display("[TB] start ignored in ACCUM, prod ignored in IDLE");
        expectBoth(11, 0, 11, 0);
        applyStimulus(1, 2, 0, 0);
        applyStimulus(1, 9, 1, 5);
        applyStimulus(0, 0, 1, 6);
        idle(1);
        applyStimulus(0, 0, 1, 77);
        applyStimulus(0, 0, 1, -300);
        checkOutput("idle_hold_acc", $signed(acc24), 11);
        idle(1);

        $display("[TB] overflow");
`ifdef BOOTH_ACC_SATURATE_EN
        expectBoth(32769, 0, 32767, 1);
`else
        expectBoth(32769, 0, -32767, 1);
`endif
        applyStimulus(1, 3, 0, 0);
        applyStimulus(0, 0, 1, 16384);
        applyStimulus(0, 0, 1, 16384);
        applyStimulus(0, 0, 1, 1);
        idle(1);
        checkOutput("ovf_sticky_idle", int'(ovf16), 1);
        expectBoth(42, 0, 42, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("ovf_cleared_by_start", int'(ovf16), 0);
        applyStimulus(0, 0, 1, 42);
        idle(2);

        $display("[TB] reset mid-run");
        applyStimulus(1, 4, 0, 0);
        applyStimulus(0, 0, 1, 1000);
        applyStimulus(0, 0, 1, 2000);
        prod_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_acc", $signed(acc24), 0);
        checkOutput("midrst_busy", int'(busy24), 0);
        checkOutput("midrst_done", int'(done24), 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        idle(2);
        expectBoth(-16384, 0, -16384, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 1, -16384);
        checkOutput("post_rst_done", int'(done24), 1);
        idle(2);

        $display("[TB] back-to-back");
        expectBoth(7, 0, 7, 0);
        expectBoth(42, 0, 42, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 1, 7);
        applyStimulus(1, 3, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("b2b_cleared", $signed(acc24), 0);
        applyStimulus(0, 0, 1, 42);
        checkOutput("b2b_second_done", int'(done24), 1);
        idle(2);

        waited = 0;
        while ((q24.size() != 0 || q16.size() != 0) && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        checkOutput("scoreboard_drained", q24.size() + q16.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
